tra_ped_ctrl_top: RTL and testbench

//  Traffic-light controller with a pedestrian push-button; this is the chip top level.
//  - Traffic light cycles GREEN -> YELLOW -> RED -> GREEN on timers.
//  - A button press is synchronised and latched as a request.
//  - The request is granted as a timed WALK pulse, only while the light is RED.
//  - Single clock domain: the request/grant path is a local handshake.

---
 rtl/tra_ped_pkg.sv | 20 ++
 rtl/ped_req_sync.sv | 38 +++
 rtl/tra_ped_ctrl_top.sv | 107 ++++++++++
 tb/tb_tra_ped_ctrl_top.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tra_ped_pkg.sv
// Shared definitions for the traffic / pedestrian controller.
//   - Light encoding on the traffic_light output: 00 GREEN, 01 YELLOW, 10 RED.
//   - light_st_e: light FSM state. The state encoding equals the output encoding,
//     so the state register drives traffic_light directly.
package tra_ped_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  typedef enum logic [1:0] {
    ST_GREEN  = LIGHT_GREEN,
    ST_YELLOW = LIGHT_YELLOW,
    ST_RED    = LIGHT_RED
  } light_st_e;

  // Width of the phase and walk down-counters. It covers durations up to 255 cycles.
  localparam int CNT_W = 8;

endpackage

// File: rtl/ped_req_sync.sv
// Pedestrian request path: 2-flop synchroniser, rising-edge detect, request latch.
//   clk_i     in  clock
//   rst_ni    in  async active-low reset
//   button_i  in  asynchronous push-button, active-high
//   ack_i     in  grant from the controller. It clears the latched request.
//   req_o     out latched request
// A rising edge that arrives on the same cycle as ack_i wins, so a new press
// is never lost.
module ped_req_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  input  logic ack_i,
  output logic req_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       req_q, req_d;
  logic       rise;

  assign rise  = sync_q[1] & ~prev_q;
  assign req_d = rise | (req_q & ~ack_i);
  assign req_o = req_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button_i};
      prev_q <= sync_q[1];
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/tra_ped_ctrl_top.sv
// Traffic-light controller with a pedestrian WALK grant (chip top).
//   clk_main       in   sole clock, rising edge
//   rst_main_n     in   async active-low reset
//   button         in   asynchronous pedestrian button
//   traffic_light  out  00 GREEN / 01 YELLOW / 10 RED (registered)
//   walk           out  pedestrian WALK (registered)
// The light cycles GREEN -> YELLOW -> RED on down-counters. A pending request
// is granted once per RED phase as a WALK_CYCLES pulse. RED holds while WALK
// is high, and also on an edge that issues a grant, so walk=1 only with RED.
module tra_ped_ctrl_top
  import tra_ped_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int RED_CYCLES    = 6,
  parameter int WALK_CYCLES   = 4
) (
  input  logic       clk_main,
  input  logic       rst_main_n,
  input  logic       button,
  output logic [1:0] traffic_light,
  output logic       walk
);

  light_st_e        state_q;
  logic [CNT_W-1:0] phase_cnt_q;
  logic [CNT_W-1:0] walk_cnt_q;
  logic             walk_q;
  logic             granted_q;  // one grant per RED phase. Cleared on RED entry.
  logic             req;
  logic             grant;
  logic             phase_done;

  ped_req_sync u_req (
    .clk_i    (clk_main),
    .rst_ni   (rst_main_n),
    .button_i (button),
    .ack_i    (grant),
    .req_o    (req)
  );

  // A request latched during WALK stays pending for the next RED, because
  // granted_q blocks a second grant in the same RED phase.
  assign grant      = (state_q == ST_RED) && req && !walk_q && !granted_q;
  assign phase_done = (phase_cnt_q == '0);

  always_ff @(posedge clk_main or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q     <= ST_GREEN;
      phase_cnt_q <= CNT_W'(GREEN_CYCLES - 1);
      granted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_GREEN: begin
          if (phase_done) begin
            state_q     <= ST_YELLOW;
            phase_cnt_q <= CNT_W'(YELLOW_CYCLES - 1);
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end
        ST_YELLOW: begin
          if (phase_done) begin
            state_q     <= ST_RED;
            phase_cnt_q <= CNT_W'(RED_CYCLES - 1);
            granted_q   <= 1'b0;
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end
        ST_RED: begin
          if (grant) granted_q <= 1'b1;
          // The counter saturates at zero. RED then waits for WALK to finish.
          if (phase_done) begin
            if (!walk_q && !grant) begin
              state_q     <= ST_GREEN;
              phase_cnt_q <= CNT_W'(GREEN_CYCLES - 1);
            end
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q     <= ST_GREEN;
          phase_cnt_q <= CNT_W'(GREEN_CYCLES - 1);
        end
      endcase
    end
  end

  always_ff @(posedge clk_main or negedge rst_main_n) begin
    if (!rst_main_n) begin
      walk_q     <= 1'b0;
      walk_cnt_q <= '0;
    end else if (grant) begin
      walk_q     <= 1'b1;
      walk_cnt_q <= CNT_W'(WALK_CYCLES - 1);
    end else if (walk_q) begin
      if (walk_cnt_q == '0) walk_q <= 1'b0;
      else                  walk_cnt_q <= walk_cnt_q - 1'b1;
    end
  end

  assign traffic_light = state_q;
  assign walk          = walk_q;

endmodule

// File: tb/tb_tra_ped_ctrl_top.sv
// Bench for tra_ped_ctrl_top. A behavioural model steps on every rising edge
// and pushes the expected (light, walk) pair. The pair is popped and compared
// on the next falling edge. Per-scenario window counters (WALK pulses, RED
// length) are compared against hand-derived constants.
module tb_tra_ped_ctrl_top;

  localparam int G = 8, Y = 2, R = 6, W = 4;

  logic       clk_main = 1'b0;
  logic       rst_main_n = 1'b0;
  logic       button = 1'b0;
  logic [1:0] traffic_light;
  logic       walk;

  int errors = 0;
  int checks = 0;

  tra_ped_ctrl_top #(
    .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .RED_CYCLES(R), .WALK_CYCLES(W)
  ) dut (
    .clk_main      (clk_main),
    .rst_main_n    (rst_main_n),
    .button        (button),
    .traffic_light (traffic_light),
    .walk          (walk)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model. Phases count elapsed cycles upward. b1..b3 hold the
  // button history as seen through the synchroniser.
  int m_light, m_el, m_wel;
  bit m_walk, m_req, m_granted, b1, b2, b3;

  function automatic void model_reset();
    m_light = 0; m_el = 0; m_wel = 0;
    m_walk = 0; m_req = 0; m_granted = 0;
    b1 = 0; b2 = 0; b3 = 0;
  endfunction

  function automatic void model_step(input bit btn);
    bit rise, gnt, done, old_walk;
    int dur;
    rise     = b2 && !b3;
    gnt      = (m_light == 2) && m_req && !m_walk && !m_granted;
    dur      = (m_light == 0) ? G : (m_light == 1) ? Y : R;
    done     = (m_el + 1 >= dur);
    old_walk = m_walk;
    if (gnt) begin
      m_walk = 1; m_wel = 0;
    end else if (m_walk) begin
      m_wel++;
      if (m_wel == W) m_walk = 0;
    end
    m_req = rise ? 1'b1 : (gnt ? 1'b0 : m_req);
    if (gnt) m_granted = 1;
    case (m_light)
      0: if (done) begin m_light = 1; m_el = 0; end else m_el++;
      1: if (done) begin m_light = 2; m_el = 0; m_granted = 0; end else m_el++;
      default: if (done && !old_walk && !gnt) begin m_light = 0; m_el = 0; end else m_el++;
    endcase
    b3 = b2; b2 = b1; b1 = btn;
  endfunction

  typedef struct packed { logic [1:0] light; logic walk; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t push_e;

  initial model_reset();

  always @(posedge clk_main) begin
    if (!rst_main_n) model_reset();
    else             model_step(button);
    push_e.light = m_light[1:0];
    push_e.walk  = m_walk;
    sb_q.push_back(push_e);
  end

  int rises = 0, red_len = 0;
  logic walk_prev = 1'b0;

  always @(negedge clk_main) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("light", traffic_light, mon_e.light);
      chk("walk", walk, mon_e.walk);
    end
    if (walk) chk("walk_only_in_red", traffic_light, 2);
    if (walk && !walk_prev) rises++;
    if (traffic_light == 2'b10) red_len++;
    walk_prev = walk;
  end

  // All driving happens 1 time unit after the falling edge, clear of the
  // compare and of the DUT sampling edge.
  task automatic step(input int n);
    repeat (n) begin @(negedge clk_main); #1; end
  endtask

  task automatic press();
    button = 1'b1; step(1); button = 1'b0;
  endtask

  task automatic start_win();
    rises = 0; red_len = 0;
  endtask

  task automatic wait_phase(input int light, input int el, input int limit);
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (m_light == light && m_el == el) return;
    end
    chk("wait_phase_timeout", m_light, light);
  endtask

  task automatic wait_walk(input int limit);
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (m_walk) return;
    end
    chk("wait_walk_timeout", m_walk, 1);
  endtask

  initial begin
    // 1: reset 3 cycles, then free-running with no requests
    rst_main_n = 1'b0;
    step(3);
    rst_main_n = 1'b1;
    start_win();
    step(48);
    chk("s1_walk_pulses", rises, 0);
    chk("s1_red_cycles", red_len, 3 * R);

    // 2: 1-cycle pulse in GREEN -> grant on 2nd RED cycle, RED stays 6
    wait_phase(0, 1, 40);
    start_win();
    press();
    wait_phase(0, 0, 40);
    chk("s2_walk_pulses", rises, 1);
    chk("s2_red_cycles", red_len, R);

    // 3: pulse in RED el0 -> walk el4..el7, RED runs to el8
    start_win();
    wait_phase(2, 0, 40);
    press();
    wait_phase(0, 0, 40);
    chk("s3_walk_pulses", rises, 1);
    chk("s3_red_cycles", red_len, 9);

    // 4: request arrives in the last RED cycle -> RED stretched to 11 cycles
    start_win();
    wait_phase(2, 2, 40);
    press();
    wait_phase(0, 0, 40);
    chk("s4_walk_pulses", rises, 1);
    chk("s4_red_cycles", red_len, 11);

    // 5a: press during WALK -> no second grant this RED, one in the next
    start_win();
    wait_phase(0, 1, 40);
    press();
    wait_walk(40);
    press();
    wait_phase(0, 0, 40);
    chk("s5a_walk_pulses_same_red", rises, 1);
    chk("s5a_red_cycles_same_red", red_len, R);
    start_win();
    wait_phase(0, 0, 40);
    chk("s5a_walk_pulses_next_red", rises, 1);
    chk("s5a_red_cycles_next_red", red_len, R);

    // 5b: three presses in one GREEN collapse into one grant
    start_win();
    press(); step(1); press(); step(1); press();
    wait_phase(0, 0, 40);
    chk("s5b_walk_pulses", rises, 1);
    chk("s5b_red_cycles", red_len, R);

    // 6: async reset mid-WALK with a press still in the synchroniser
    wait_phase(0, 1, 40);
    press();
    wait_walk(40);
    step(1);
    press();
    #2 rst_main_n = 1'b0;
    #1;
    chk("s6_async_light", traffic_light, 0);
    chk("s6_async_walk", walk, 0);
    step(2);
    rst_main_n = 1'b1;
    start_win();
    step(36);
    chk("s6_walk_pulses_after_reset", rises, 0);
    chk("s6_red_cycles_after_reset", red_len, 2 * R);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
